// File: rtl/mc_sequencer.sv
// Microcode phase sequencer: steps each instruction through phases 0..len-1,
// with the length looked up per instruction class from a writable table.
module mc_sequencer #(
  parameter int unsigned NUM_CLASS   = 8,
  parameter int unsigned MAX_PHASE   = 8,
  parameter int unsigned DEFAULT_LEN = 4,
  localparam int unsigned CW = $clog2(NUM_CLASS),
  localparam int unsigned PW = $clog2(MAX_PHASE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CW-1:0]        class_id,
  input  logic                 skip_req,
  input  logic                 unit_busy,
  input  logic                 exc_req,
  input  logic                 cfg_we,
  input  logic [CW-1:0]        cfg_class,
  input  logic [PW-1:0]        cfg_len,
  output logic [PW-1:0]        phase,
  output logic [MAX_PHASE-1:0] phase_oh,
  output logic                 fetch_en,
  output logic                 last_phase,
  output logic                 stall,
  output logic                 instr_done,
  output logic                 exc_taken,
  output logic [31:0]          instr_count
);

  typedef enum logic {HOLD, RUN} state_t;

  state_t        state, state_d;
  logic [PW-1:0] phase_d;
  logic [PW-1:0] cur_len;
  logic [PW-1:0] eff_len;
  logic [PW-1:0] last_idx;
  logic [PW-1:0] len_tbl [NUM_CLASS];
  logic [PW-1:0] cfg_len_clamped;

  always_comb begin
    if (cfg_len < PW'(2))
      cfg_len_clamped = PW'(2);
    else if (cfg_len > PW'(MAX_PHASE))
      cfg_len_clamped = PW'(MAX_PHASE);
    else
      cfg_len_clamped = cfg_len;
  end

  // Phase 1 decides its exit from the table directly; later phases use the latched copy.
  always_comb begin
    eff_len  = (state == RUN && phase == PW'(1)) ? len_tbl[class_id] : cur_len;
    last_idx = eff_len - PW'(1);
  end

  always_comb begin
    state_d    = state;
    phase_d    = phase;
    last_phase = 1'b0;
    stall      = 1'b0;
    instr_done = 1'b0;
    exc_taken  = 1'b0;
    case (state)
      HOLD: begin
        state_d = RUN;
        phase_d = '0;
      end
      RUN: begin
        last_phase = (phase == last_idx);
        if (phase == '0) begin
          phase_d = PW'(1);
        end else if (exc_req) begin
          phase_d   = '0;
          exc_taken = 1'b1;
        end else if (phase == last_idx) begin
          if (unit_busy) begin
            stall = 1'b1;
          end else begin
            phase_d    = '0;
            instr_done = 1'b1;
          end
        end else if (skip_req && (phase + PW'(1) < last_idx)) begin
          phase_d = last_idx;
        end else begin
          phase_d = phase + PW'(1);
        end
      end
      default: state_d = HOLD;
    endcase
    // A reset edge discards the current cycle, so no strobe may complete in it.
    if (rst) begin
      last_phase = 1'b0;
      stall      = 1'b0;
      instr_done = 1'b0;
      exc_taken  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HOLD;
      phase       <= '0;
      cur_len     <= PW'(DEFAULT_LEN);
      instr_count <= '0;
      for (int unsigned i = 0; i < NUM_CLASS; i++)
        len_tbl[i] <= PW'(DEFAULT_LEN);
    end else begin
      state <= state_d;
      phase <= phase_d;
      if (state == RUN && phase == PW'(1))
        cur_len <= eff_len;
      if (instr_done)
        instr_count <= instr_count + 32'd1;
      if (cfg_we)
        len_tbl[cfg_class] <= cfg_len_clamped;
    end
  end

  always_comb begin
    fetch_en = (state == RUN) && (phase == '0);
    for (int unsigned k = 0; k < MAX_PHASE; k++)
      phase_oh[k] = (state == RUN) && (phase == PW'(k));
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: stimulus queues hand-derived per-cycle
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_mc_sequencer;
  localparam int unsigned NC = 8;
  localparam int unsigned MP = 8;
  localparam int unsigned CW = 3;
  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] class_id;
  logic          skip_req, unit_busy, exc_req;
  logic          cfg_we;
  logic [CW-1:0] cfg_class;
  logic [PW-1:0] cfg_len;
  logic [PW-1:0] phase;
  logic [MP-1:0] phase_oh;
  logic          fetch_en, last_phase, stall, instr_done, exc_taken;
  logic [31:0]   instr_count;

  mc_sequencer #(.NUM_CLASS(NC), .MAX_PHASE(MP), .DEFAULT_LEN(4)) dut (
    .clk(clk), .rst(rst), .class_id(class_id), .skip_req(skip_req),
    .unit_busy(unit_busy), .exc_req(exc_req), .cfg_we(cfg_we),
    .cfg_class(cfg_class), .cfg_len(cfg_len), .phase(phase),
    .phase_oh(phase_oh), .fetch_en(fetch_en), .last_phase(last_phase),
    .stall(stall), .instr_done(instr_done), .exc_taken(exc_taken),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ph;
    bit          run, lst, stl, dn, et;
    int unsigned cnt;
  } exp_t;

  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cnt   = 0;
  int unsigned cycno = 0;

  // Monitor: one comparison per expected cycle record
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [PW+MP+5+32-1:0] act, req;
      logic [MP-1:0] oh;
      e  = sb.pop_front();
      oh = '0;
      if (e.run) oh[e.ph] = 1'b1;
      req = {PW'(e.ph), oh, e.run && (e.ph == 0), e.lst, e.stl, e.dn, e.et, e.cnt};
      act = {phase, phase_oh, fetch_en, last_phase, stall, instr_done, exc_taken, instr_count};
      total++;
      if (act !== req) begin
        bad++;
        $display("FAIL cycle%0d: got ph=%0d oh=%b f=%b l=%b s=%b d=%b e=%b cnt=%0d, want ph=%0d oh=%b f=%b l=%b s=%b d=%b e=%b cnt=%0d",
                 cycno, phase, phase_oh, fetch_en, last_phase, stall, instr_done, exc_taken, instr_count,
                 e.ph, oh, req[36], e.lst, e.stl, e.dn, e.et, e.cnt);
      end
      cycno++;
    end
  end

  task automatic cyc(input int ph, input bit run, input bit lst, input bit stl,
                     input bit dn, input bit et);
    exp_t e;
    e.ph = ph; e.run = run; e.lst = lst; e.stl = stl; e.dn = dn; e.et = et; e.cnt = cnt;
    sb.push_back(e);
    if (dn) cnt++;
    @(posedge clk); #1;
    if (rst) cnt = 0;
    skip_req = 0; unit_busy = 0; exc_req = 0; cfg_we = 0;
  endtask

  task automatic instr(input int len);
    for (int p = 0; p < len; p++)
      cyc(p, 1, p == len - 1, 0, p == len - 1, 0);
  endtask

  task automatic cfg(input int c, input int l);
    cfg_we = 1; cfg_class = CW'(c); cfg_len = PW'(l);
  endtask

  initial begin
    rst = 1; class_id = 3; skip_req = 0; unit_busy = 0; exc_req = 0;
    cfg(5, 6);                       // must be ignored under reset
    repeat (2) @(posedge clk);
    #1;
    cfg(5, 6);
    cyc(0, 0, 0, 0, 0, 0);           // reset still high, HOLD
    rst = 0;
    cfg(7, 7);                       // accepted in HOLD
    cyc(0, 0, 0, 0, 0, 0);
    // steady class 3, default length 4
    repeat (3) instr(4);
    // class 5 still default, then reprogrammed to 6
    class_id = 5; instr(4);
    cfg(5, 6); instr(6);
    class_id = 7; instr(7);
    // in-flight length survives a rewrite
    class_id = 5;
    for (int p = 0; p < 6; p++) begin
      if (p == 2) cfg(5, 1);
      cyc(p, 1, p == 5, 0, p == 5, 0);
    end
    instr(2);
    cfg(5, 12); instr(8);
    // skip on length 5
    cfg(2, 5); class_id = 2;
    cyc(0, 1, 0, 0, 0, 0);
    skip_req = 1; cyc(1, 1, 0, 0, 0, 0);
    cyc(4, 1, 1, 0, 1, 0);
    // skip on length 2 has no effect
    cfg(6, 0); class_id = 6;
    cyc(0, 1, 0, 0, 0, 0);
    skip_req = 1; cyc(1, 1, 1, 0, 1, 0);
    // busy stall in final phase
    class_id = 3;
    cyc(0, 1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0); cyc(2, 1, 0, 0, 0, 0);
    repeat (3) begin unit_busy = 1; cyc(3, 1, 1, 1, 0, 0); end
    cyc(3, 1, 1, 0, 1, 0);
    // exception during stall
    cyc(0, 1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0); cyc(2, 1, 0, 0, 0, 0);
    unit_busy = 1; cyc(3, 1, 1, 1, 0, 0);
    unit_busy = 1; exc_req = 1; cyc(3, 1, 1, 0, 0, 1);
    // exception outranks skip at phase 1
    cyc(0, 1, 0, 0, 0, 0);
    exc_req = 1; skip_req = 1; cyc(1, 1, 0, 0, 0, 1);
    instr(4);
    // write coinciding with phase-1 lookup of the same class
    cfg(5, 3); class_id = 5; instr(3);
    cyc(0, 1, 0, 0, 0, 0);
    cfg(5, 6); cyc(1, 1, 0, 0, 0, 0);
    cyc(2, 1, 1, 0, 1, 0);
    // reset mid-instruction
    cyc(0, 1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0);
    rst = 1; cyc(2, 1, 0, 0, 0, 0);
    rst = 0; cyc(0, 0, 0, 0, 0, 0);
    instr(4);
    @(negedge clk); @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d records left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
